dht_multi_ch_ctrl: RTL
======================

// Module: dht_multi_ch_ctrl
// PURPOSE
//  Multi-channel DHT11/DHT22 single-wire sensor controller: the parametrised successor of the single-sensor dht11 IP core.
//  Shares one protocol engine across NUM_CH sensor pins, polled sequentially (sweep ch0..NUM_CH-1).
//  Validates the checksum and keeps per-channel result/error registers for an AXI4-Lite register wrapper.
//  Supports a software trigger plus a periodic auto-sweep.
// PARAMETERS
//  CLK_HZ          100_000_000  clk frequency; 1us tick = CLK_HZ/1_000_000 cycles
//  NUM_CH          2            number of sensor channels (1..8)
//  START_LOW_US    18000        host start pulse length (DHT11 18ms; DHT22 may use 1000)
//  BIT_THRESH_US   50           data-high length > threshold -> bit 1, else bit 0
//  TIMEOUT_US      255          max length of any sensor-driven phase
//  AUTO_PERIOD_MS  2000         auto-sweep period
// PORTS
//  clk          in   1         system clock
//  reset_p      in   1         synchronous reset, active-high
//  start        in   1         1-cycle pulse; begin a sweep if idle
//  auto_en      in   1         1 = periodic sweeps every AUTO_PERIOD_MS
//  dht_in       in   NUM_CH    pad input per channel (asynchronous)
//  dht_drive_low out NUM_CH    1 = top level drives pad 0; 0 = pad released (Z)
//  busy         out  1         sweep in progress
//  done         out  1         1-cycle pulse at end of each channel read
//  done_ch      out  3         channel index qualified by done
//  data_out     out  NUM_CH*32 per channel {hum_int,hum_dec,tmp_int,tmp_dec}, ch0 in [31:0]
//  crc_err      out  NUM_CH    last read of channel had checksum mismatch
//  timeout_err  out  NUM_CH    last read of channel timed out
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, tick/period counters 0, every dht_drive_low released.
//  - dht_in: 2-FF synchroniser per channel, then edge detect on the selected channel; 2-cycle input latency.
//  - Phase counter counts 1us ticks, restarts at every state change, saturates at TIMEOUT_US.
//  - FSM states:
//    - IDLE: start pulse or auto-period expiry -> ch=0, busy=1, go to START_LOW.
//    - START_LOW: dht_drive_low[ch]=1 for START_LOW_US, then release -> WAIT_RESP.
//    - WAIT_RESP -> RESP_LOW on falling edge.
//    - RESP_LOW -> RESP_HIGH on rising edge.
//    - RESP_HIGH -> BIT_LOW on falling edge.
//    - BIT_LOW -> BIT_HIGH on rising edge.
//    - BIT_HIGH, on falling edge:
//      - shift in (cnt > BIT_THRESH_US); bit counter++.
//      - after 40 bits -> CHECK, else -> BIT_LOW.
//    - Any sensor phase reaching TIMEOUT_US -> END with timeout.
//    - CHECK: (b0+b1+b2+b3) mod 256 == b4 -> data_out[ch] <= b0..b3, crc_err[ch]=0; else data kept, crc_err[ch]=1.
//    - END: done=1, done_ch=ch; timeout_err[ch] set on timeout / cleared otherwise (crc_err[ch] untouched on timeout).
//      - ch < NUM_CH-1 -> ch++, START_LOW; otherwise -> IDLE, busy=0.
//  - MSB-first: bit 39 first; b0 = bits[39:32].
//  - start while busy: ignored.
//  - Auto period counter runs only in IDLE with auto_en=1; expiry while busy is not possible (held).
//  - auto_en and start in the same cycle: one sweep only.
//  - Reset mid-read: next cycle IDLE, pad released, results cleared.
// CONFIGURATION
//  - DHT_ERR_CNT_EN defined:
//    - Adds output err_cnt [NUM_CH*8-1:0]: per-channel 8-bit counter of failed reads (crc or timeout).
//    - Saturates at 255; reset to 0.
//  - Undefined: port and counters absent; all other behaviour identical.
// TESTING  (bench uses CLK_HZ=1_000_000, START_LOW_US=20, AUTO_PERIOD_MS=1)
//  1. ch0 model sends 35 00 18 05 52 -> data_out[31:0]=0x35001805, crc_err[0]=0, done with done_ch=0.
//  2. ch0 sends 35 00 18 05 53 -> data_out[31:0] unchanged, crc_err[0]=1, err_cnt[7:0]=1 (with DHT_ERR_CNT_EN).
//  3. ch0 silent -> pad released after 20 cycles, timeout_err[0]=1 at 20+255 ticks, busy continues to ch1.
//  4. NUM_CH=2, ch1 sends 40 00 1A 00 5A -> done_ch 0 then 1; busy high throughout; data_out[63:32]=0x40001A00.
//  5. start pulsed mid-sweep -> no extra sweep. auto_en=1 held -> a new sweep starts 1000 ticks after each IDLE entry.
//  6. reset_p asserted in BIT_HIGH -> next cycle: busy=0, dht_drive_low=0, data_out=0, FSM IDLE.

Source files
------------

// File: rtl/dht_multi_ch_ctrl.sv
// dht_multi_ch_ctrl: multi-channel DHT11/DHT22 controller sharing one protocol engine across NUM_CH pads
// Ports: clk/reset_p (sync, active-high); start pulse and auto_en trigger sweeps ch0..NUM_CH-1;
// dht_in async pads, dht_drive_low pull-down enables; busy, done/done_ch per channel read;
// data_out {hum_int,hum_dec,tmp_int,tmp_dec} per channel, crc_err/timeout_err per channel.
// Build option DHT_ERR_CNT_EN adds err_cnt: saturating 8-bit failed-read counter per channel.
module dht_multi_ch_ctrl #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int NUM_CH         = 2,
  parameter int START_LOW_US   = 18000,
  parameter int BIT_THRESH_US  = 50,
  parameter int TIMEOUT_US     = 255,
  parameter int AUTO_PERIOD_MS = 2000
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic [NUM_CH-1:0]    dht_in,
  output logic [NUM_CH-1:0]    dht_drive_low,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           done_ch,
  output logic [NUM_CH*32-1:0] data_out,
  output logic [NUM_CH-1:0]    crc_err,
`ifdef DHT_ERR_CNT_EN
  output logic [NUM_CH*8-1:0]  err_cnt,
  output logic [NUM_CH-1:0]    timeout_err
`else
  output logic [NUM_CH-1:0]    timeout_err
`endif
);
  localparam int TICK_DIV     = CLK_HZ / 1_000_000;
  localparam int PERIOD_TICKS = AUTO_PERIOD_MS * 1000;
  localparam int CNT_MAX      = START_LOW_US > TIMEOUT_US ? START_LOW_US : TIMEOUT_US;
  localparam int CW           = $clog2(CNT_MAX + 1);
  localparam int TW           = $clog2(TICK_DIV + 1);
  localparam int PW           = $clog2(PERIOD_TICKS + 1);
  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, END_RD
  } state_t;
  state_t state, state_n;
  logic [2:0] ch, ch_n;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [NUM_CH-1:0] s1, s2, ch_oh;
  logic prev, sel, fall, rise, tick, tmo, expire, last, crc_ok, fail_to;
  logic [39:0] shreg;
  logic [5:0] bits;
  logic [7:0] sum;
  assign tick    = tick_cnt == TW'(TICK_DIV - 1);
  assign ch_oh   = NUM_CH'(1) << ch;
  assign sel     = |(s2 & ch_oh);
  assign fall    = prev & ~sel;
  assign rise    = ~prev & sel;
  assign tmo     = tick && cnt == CW'(TIMEOUT_US - 1);
  assign expire  = auto_en && tick && pcnt == PW'(PERIOD_TICKS - 1);
  assign last    = ch == 3'(NUM_CH - 1);
  assign sum     = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign crc_ok  = sum == shreg[7:0];
  // every path into END_RD other than CHECK is a sensor-phase timeout
  assign fail_to = state_n == END_RD && state != CHECK;
  assign busy    = state != IDLE;
  assign done    = state == END_RD;
  assign done_ch = ch;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = (start || expire) ? START_LOW : IDLE;
      START_LOW: state_n = (tick && cnt == CW'(START_LOW_US - 1)) ? WAIT_RESP : START_LOW;
      WAIT_RESP: state_n = tmo ? END_RD : fall ? RESP_LOW : WAIT_RESP;
      RESP_LOW:  state_n = tmo ? END_RD : rise ? RESP_HIGH : RESP_LOW;
      RESP_HIGH: state_n = tmo ? END_RD : fall ? BIT_LOW : RESP_HIGH;
      BIT_LOW:   state_n = tmo ? END_RD : rise ? BIT_HIGH : BIT_LOW;
      BIT_HIGH:  state_n = tmo ? END_RD : !fall ? BIT_HIGH : bits == 6'd39 ? CHECK : BIT_LOW;
      CHECK:     state_n = END_RD;
      END_RD:    state_n = last ? IDLE : START_LOW;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    ch_n   = state == IDLE ? 3'd0 : (state == END_RD && !last) ? ch + 3'd1 : ch;
    // the period only accumulates while idle and enabled, so every idle entry restarts it
    pcnt_n = (state == IDLE && auto_en && !start && !expire) ? pcnt + PW'(tick) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state         <= IDLE;
      ch            <= '0;
      cnt           <= '0;
      tick_cnt      <= '0;
      pcnt          <= '0;
      s1            <= '0;
      s2            <= '0;
      prev          <= 1'b0;
      shreg         <= '0;
      bits          <= '0;
      dht_drive_low <= '0;
      data_out      <= '0;
      crc_err       <= '0;
      timeout_err   <= '0;
    end else begin
      state         <= state_n;
      ch            <= ch_n;
      cnt           <= state_n != state ? '0 : (tick && cnt != CW'(CNT_MAX)) ? cnt + CW'(1) : cnt;
      tick_cnt      <= tick ? '0 : tick_cnt + TW'(1);
      pcnt          <= pcnt_n;
      s1            <= dht_in;
      s2            <= s1;
      prev          <= sel;
      dht_drive_low <= state_n == START_LOW ? NUM_CH'(1) << ch_n : '0;
      if (state == START_LOW)
        bits <= '0;
      else if (state == BIT_HIGH && fall) begin
        shreg <= {shreg[38:0], cnt > CW'(BIT_THRESH_US)};
        bits  <= bits + 6'd1;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (state == CHECK && crc_ok && ch_oh[i]) data_out[i*32 +: 32] <= shreg[39:8];
      if (state == CHECK) begin
        crc_err     <= crc_ok ? crc_err & ~ch_oh : crc_err | ch_oh;
        timeout_err <= timeout_err & ~ch_oh;
      end else if (fail_to)
        timeout_err <= timeout_err | ch_oh;
    end
  end
`ifdef DHT_ERR_CNT_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (reset_p)
        err_cnt[i*8 +: 8] <= '0;
      else if (ch_oh[i] && (fail_to || (state == CHECK && !crc_ok)) && err_cnt[i*8 +: 8] != 8'hFF)
        err_cnt[i*8 +: 8] <= err_cnt[i*8 +: 8] + 8'd1;
  end
`endif
endmodule
